// File: rtl/nonconsec_pkg.sv
// nonconsec_pkg: shared state/error-mode types and the pulse-target helper for nonconsec_seq_gen
package nonconsec_pkg;
   typedef enum logic [2:0] {IDLE, A, LEAD, B, GAP, TAIL, C} state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_EXTRA_B, ERR_MISSING_B, ERR_NO_C} err_mode_e;
   // number of b pulses the sequence emits for a given error mode
   function automatic int target_count(err_mode_e m, int b_count);
      return m == ERR_EXTRA_B ? b_count + 1 : m == ERR_MISSING_B ? b_count - 1 : b_count;
   endfunction
endpackage

// File: rtl/nonconsec_seq_gen.sv
// nonconsec_seq_gen: drives a, then N b pulses with programmable gaps, then c ("a |=> b[=N] ##1 c")
// Ports: clk/rst_n (async active-low); start_i requests a sequence while idle;
// lead_i/gap_i/tail_i idle-cycle counts; err_mode_i selects legal or faulty sequence;
// a_o/b_o/c_o protocol pulses; busy_o sequence in progress; done_o pulses in the final cycle.
module nonconsec_seq_gen
   import nonconsec_pkg::*;
#(
   parameter int B_COUNT = 3,
   parameter int GAP_W   = 4,
   parameter int TAIL_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [GAP_W-1:0]  lead_i,
   input  logic [GAP_W-1:0]  gap_i,
   input  logic [TAIL_W-1:0] tail_i,
   input  logic [1:0]        err_mode_i,
   output logic              a_o,
   output logic              b_o,
   output logic              c_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int CNT_W = GAP_W > TAIL_W ? GAP_W : TAIL_W;
   localparam int PC_W  = $clog2(B_COUNT + 2);
   state_e            r_state;
   state_e            w_next;
   err_mode_e         r_mode;
   logic [GAP_W-1:0]  r_lead;
   logic [GAP_W-1:0]  r_gap;
   logic [TAIL_W-1:0] r_tail;
   logic [CNT_W-1:0]  r_cnt;
   logic [PC_W-1:0]   r_pcnt;
   logic [PC_W-1:0]   w_target;
   logic              w_last;
   logic              r_a, r_b, r_c, r_busy, r_done;
   assign w_target = PC_W'(target_count(r_mode, B_COUNT));
   assign w_last   = (r_pcnt + PC_W'(1)) == w_target;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     w_next = start_i ? A : IDLE;
         A:        w_next = r_lead != '0 ? LEAD : B;
         LEAD,
         GAP:      w_next = r_cnt == '0 ? B : r_state;
         B:        w_next = w_last ? (r_tail != '0 ? TAIL : C) : (r_gap != '0 ? GAP : B);
         TAIL:     w_next = r_cnt == '0 ? C : TAIL;
         C:        w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end
   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   // The single wait counter is loaded with (count-1) in the cycle before the wait state is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mode  <= ERR_NONE;
         r_lead  <= '0;
         r_gap   <= '0;
         r_tail  <= '0;
         r_cnt   <= '0;
         r_pcnt  <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_c     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start_i) begin
            r_lead <= lead_i;
            r_gap  <= gap_i;
            r_tail <= tail_i;
            r_mode <= err_mode_e'(err_mode_i);
         end
         r_pcnt <= r_state == A ? '0 : r_state == B ? r_pcnt + PC_W'(1) : r_pcnt;
         r_cnt  <= r_state == A ? CNT_W'(r_lead) - CNT_W'(1) :
                   r_state == B ? (w_last ? CNT_W'(r_tail) : CNT_W'(r_gap)) - CNT_W'(1) :
                   r_cnt != '0 ? r_cnt - CNT_W'(1) : r_cnt;
         r_a    <= w_next == A;
         r_b    <= w_next == B;
         r_c    <= w_next == C && r_mode != ERR_NO_C;
         r_done <= w_next == C;
         r_busy <= w_next != IDLE;
      end
   end
   assign a_o    = r_a;
   assign b_o    = r_b;
   assign c_o    = r_c;
   assign busy_o = r_busy;
   assign done_o = r_done;
endmodule
